// File: rtl/buzzer_pkg.sv
// Shared note codes, pitch table and FSM encoding for the buzzer tone path.
// The beat scheduler imports the same note codes.
package buzzer_pkg;

  localparam logic [3:0] C_M  = 4'd0;
  localparam logic [3:0] D_M  = 4'd1;
  localparam logic [3:0] E_M  = 4'd2;
  localparam logic [3:0] F_M  = 4'd3;
  localparam logic [3:0] G_M  = 4'd4;
  localparam logic [3:0] A_M  = 4'd5;
  localparam logic [3:0] B_M  = 4'd6;
  localparam logic [3:0] C2_M = 4'd7;
  localparam logic [3:0] S_M  = 4'd8;

  // Pitch frequencies in millihertz, C4 up to C5.
  localparam int unsigned NOTE_MHZ [8] = '{
    261630, 293660, 329630, 349230, 392000, 440000, 493880, 523250
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SILENT = 2'd1,
    ST_TONE   = 2'd2
  } state_t;

  // Rounded half-period in clock cycles: (CLK_HZ*1000 + f) / (2f), f in mHz.
  function automatic longint unsigned half_period(input longint unsigned clk_hz,
                                                  input logic [2:0]      idx);
    longint unsigned f2;
    f2 = 64'(NOTE_MHZ[idx]) * 64'd2;
    return (clk_hz * 64'd1000 + f2 / 64'd2) / f2;
  endfunction

endpackage

// File: rtl/note_period_lut.sv
// Combinational map from a 3-bit pitch code to its half-period in clock cycles.
module note_period_lut
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int          CNT_W  = 16
) (
  input  logic [2:0]       i_code,
  output logic [CNT_W-1:0] o_half
);

  logic [CNT_W-1:0] w_tab [8];

  for (genvar g = 0; g < 8; g++) begin : g_tab
    assign w_tab[g] = CNT_W'(half_period(64'(CLK_HZ), 3'(g)));
  end

  assign o_half = w_tab[i_code];

endmodule

// File: rtl/buzzer_tone_gen.sv
// Piezo square-wave generator: registers the note select, runs the
// IDLE/SILENT/TONE FSM and toggles the pin every half-period.
module buzzer_tone_gen
  import buzzer_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12000000,
  parameter int          CNT_W  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] NS,
  input  logic       enable,
  output logic       buzzer,
  output logic       tone_active,
  output logic       note_start
);

  logic [3:0]       r_ns_q;
  logic             r_en_q;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_pitch;
  logic             r_buzzer;
  logic             r_tone_active;
  logic             r_note_start;

  state_t           w_state_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [2:0]       w_pitch_n;
  logic             w_buzzer_n;
  logic             w_start_n;
  logic             w_rest;
  logic [CNT_W-1:0] w_half;

  note_period_lut #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) u_lut (
    .i_code (r_ns_q[2:0]),
    .o_half (w_half)
  );

  assign w_rest = (r_ns_q >= S_M);

  // Exit order follows priority: disable, rest, pitch change, terminal count.
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_pitch_n  = r_pitch;
    w_buzzer_n = r_buzzer;
    w_start_n  = 1'b0;
    case (r_state)
      ST_IDLE, ST_SILENT: begin
        w_cnt_n    = '0;
        w_buzzer_n = 1'b0;
        if (!r_en_q) begin
          w_state_n = ST_IDLE;
        end else if (w_rest) begin
          w_state_n = ST_SILENT;
        end else begin
          w_state_n = ST_TONE;
          w_pitch_n = r_ns_q[2:0];
          w_start_n = 1'b1;
        end
      end
      ST_TONE: begin
        if (!r_en_q || w_rest) begin
          w_state_n  = r_en_q ? ST_SILENT : ST_IDLE;
          w_cnt_n    = '0;
          w_buzzer_n = 1'b0;
        end else if (r_ns_q[2:0] != r_pitch) begin
          w_pitch_n  = r_ns_q[2:0];
          w_cnt_n    = '0;
          w_buzzer_n = 1'b0;
          w_start_n  = 1'b1;
        end else if (r_cnt == w_half - CNT_W'(1)) begin
          w_cnt_n    = '0;
          w_buzzer_n = ~r_buzzer;
        end else begin
          w_cnt_n    = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_n  = ST_IDLE;
        w_cnt_n    = '0;
        w_buzzer_n = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ns_q        <= S_M;
      r_en_q        <= 1'b0;
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_pitch       <= 3'd0;
      r_buzzer      <= 1'b0;
      r_tone_active <= 1'b0;
      r_note_start  <= 1'b0;
    end else begin
      r_ns_q        <= NS;
      r_en_q        <= enable;
      r_state       <= w_state_n;
      r_cnt         <= w_cnt_n;
      r_pitch       <= w_pitch_n;
      r_buzzer      <= w_buzzer_n;
      r_tone_active <= (w_state_n == ST_TONE);
      r_note_start  <= w_start_n;
    end
  end

  assign buzzer      = r_buzzer;
  assign tone_active = r_tone_active;
  assign note_start  = r_note_start;

endmodule

// File: tb/tb_buzzer_tone_gen.sv
// Directed bench for buzzer_tone_gen at a reduced 1.2 MHz clock so every
// half-period stays short; expected half-periods are hand-rounded values.
module tb_buzzer_tone_gen;
  import buzzer_pkg::*;

  // round(1.2e9 / (2 * f_mHz)) for the reduced clock
  localparam int H_C4 = 2293;
  localparam int H_E4 = 1820;
  localparam int H_A4 = 1364;
  localparam int H_C5 = 1147;
  localparam int BOUND = 5000;

  logic       clk;
  logic       rst_n;
  logic [3:0] NS;
  logic       enable;
  logic       buzzer;
  logic       tone_active;
  logic       note_start;

  int n_cmp;
  int n_err;
  int n;
  int p;
  int hi_cnt;
  int ns_cnt;

  buzzer_tone_gen #(.CLK_HZ(1200000), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .NS          (NS),
    .enable      (enable),
    .buzzer      (buzzer),
    .tone_active (tone_active),
    .note_start  (note_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until buzzer reaches lvl; returns cycles taken and note_start pulses seen.
  task automatic measure(input logic lvl, output int cyc, output int pulses);
    cyc = 0;
    pulses = 0;
    do begin
      step();
      cyc++;
      if (note_start) pulses++;
    end while (buzzer !== lvl && cyc < BOUND);
  endtask

  task automatic idle_window(input int cycles, output int highs, output int starts);
    highs = 0;
    starts = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (buzzer) highs++;
      if (note_start) starts++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    enable = 1'b0;
    NS = 4'd0;
    repeat (3) step();
    chk("rst_buzzer", 32'(buzzer), 0);
    chk("rst_tone_active", 32'(tone_active), 0);
    chk("rst_note_start", 32'(note_start), 0);

    // A4 from reset
    rst_n = 1'b1;
    enable = 1'b1;
    NS = A_M;
    step();
    chk("a4_pre_entry_active", 32'(tone_active), 0);
    step();
    chk("a4_entry_active", 32'(tone_active), 1);
    chk("a4_entry_start", 32'(note_start), 1);
    chk("a4_entry_buzzer", 32'(buzzer), 0);
    measure(1'b1, n, p);
    chk("a4_first_rise", 32'(n), 32'(H_A4));
    chk("a4_rise_pulses", 32'(p), 0);
    measure(1'b0, n, p);
    chk("a4_first_fall", 32'(n), 32'(H_A4));
    measure(1'b1, n, p);
    chk("a4_second_rise", 32'(n), 32'(H_A4));

    // Pitch change A4 -> C4 mid half-period while buzzer is high
    repeat (50) step();
    NS = C_M;
    step();
    chk("chg_buzzer_hold", 32'(buzzer), 1);
    step();
    chk("chg_buzzer_clear", 32'(buzzer), 0);
    chk("chg_start", 32'(note_start), 1);
    chk("chg_active", 32'(tone_active), 1);
    measure(1'b1, n, p);
    chk("c4_first_rise", 32'(n), 32'(H_C4));
    chk("c4_pulses", 32'(p), 0);

    // Rest codes 8 and 12
    NS = S_M;
    repeat (2) step();
    chk("rest8_buzzer", 32'(buzzer), 0);
    chk("rest8_active", 32'(tone_active), 0);
    chk("rest8_state", 32'(dut.r_state), 32'(ST_SILENT));
    idle_window(200, hi_cnt, ns_cnt);
    chk("rest8_highs", 32'(hi_cnt), 0);
    chk("rest8_starts", 32'(ns_cnt), 0);
    NS = 4'd12;
    idle_window(200, hi_cnt, ns_cnt);
    chk("rest12_highs", 32'(hi_cnt), 0);
    chk("rest12_starts", 32'(ns_cnt), 0);
    chk("rest12_active", 32'(tone_active), 0);
    chk("rest12_state", 32'(dut.r_state), 32'(ST_SILENT));

    // E4 held across a beat boundary (same code rewritten)
    NS = E_M;
    repeat (2) step();
    chk("e4_entry_start", 32'(note_start), 1);
    measure(1'b1, n, p);
    chk("e4_first_rise", 32'(n), 32'(H_E4));
    repeat (500) step();
    NS = E_M;
    measure(1'b0, n, p);
    chk("e4_fall_after_beat", 32'(n + 500), 32'(H_E4));
    chk("e4_beat_pulses", 32'(p), 0);
    measure(1'b1, n, p);
    chk("e4_next_rise", 32'(n), 32'(H_E4));

    // Disable and rest code in the same cycle: IDLE wins
    repeat (10) step();
    enable = 1'b0;
    NS = 4'd9;
    repeat (2) step();
    chk("dis_buzzer", 32'(buzzer), 0);
    chk("dis_active", 32'(tone_active), 0);
    chk("dis_state", 32'(dut.r_state), 32'(ST_IDLE));

    // Reset mid-tone with buzzer high, then C5 restart
    enable = 1'b1;
    NS = C2_M;
    repeat (2) step();
    chk("c5_entry_start", 32'(note_start), 1);
    measure(1'b1, n, p);
    chk("c5_first_rise", 32'(n), 32'(H_C5));
    repeat (20) step();
    rst_n = 1'b0;
    step();
    chk("rst2_buzzer", 32'(buzzer), 0);
    chk("rst2_active", 32'(tone_active), 0);
    chk("rst2_start", 32'(note_start), 0);
    chk("rst2_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rst2_cnt", 32'(dut.r_cnt), 0);
    rst_n = 1'b1;
    repeat (2) step();
    chk("c5_reentry_start", 32'(note_start), 1);
    chk("c5_reentry_active", 32'(tone_active), 1);
    measure(1'b1, n, p);
    chk("c5_rise_after_reset", 32'(n), 32'(H_C5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
